// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor input, memory write port and status bundle of the instruction encoder
// master drives session control, descriptors and wr_ready; slave is the encoder
interface instr_encoder_if;
    logic        start;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        busy;
    logic        done;
    logic        err;
    modport master (
        output start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
    modport slave (
        input  start, base_addr, in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, in_last, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: encodes instruction descriptors into RV32I words and writes them to sequential memory addresses
// ports: clk, rst (async active-high); bus (slave) carries start/base_addr, the descriptor stream, the write port and busy/done/err
module instr_encoder (
    input logic            clk,
    input logic            rst,
    instr_encoder_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, enc;
    logic        wr_en_q, wr_en_d, err_q, err_d;
    logic        ok, accept, hs, go, fit12, fit13, fit21;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    assign imm = bus.in_imm;
    assign rd  = bus.in_rd;
    assign rs1 = bus.in_rs1;
    assign rs2 = bus.in_rs2;
    // a value fits in N signed bits when all bits above N-1 equal the sign bit
    assign fit12 = &imm[31:11] | ~|imm[31:11];
    assign fit13 = &imm[31:12] | ~|imm[31:12];
    assign fit21 = &imm[31:20] | ~|imm[31:20];
    assign ok = bus.in_op < 3'd2  ? 1'b1 :
                bus.in_op == 3'd5 ? fit13 & ~imm[0] :
                bus.in_op == 3'd6 ? fit21 & ~imm[0] : fit12;
    always_comb begin
        enc = NOP;
        case (bus.in_op)
            3'd0: enc = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd1: enc = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'd2: enc = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
            3'd3: enc = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd4: enc = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            3'd5: enc = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
            3'd6: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            3'd7: enc = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            default: enc = NOP;
        endcase
    end
    assign go          = state_q == IDLE && bus.start;
    assign bus.in_ready = state_q == LOAD && (!wr_en_q || bus.wr_ready);
    assign accept      = bus.in_valid && bus.in_ready;
    assign hs          = wr_en_q && bus.wr_ready;
    // the counter always holds the address of the pending (or next) write, so a
    // reload in the same cycle as a handshake picks up the already-advanced slot
    assign addr_d  = go ? bus.base_addr : hs ? addr_q + 32'd4 : addr_q;
    assign data_d  = accept ? (ok ? enc : NOP) : data_q;
    assign wr_en_d = accept | (wr_en_q & ~bus.wr_ready);
    assign err_d   = go ? 1'b0 : err_q | (accept & ~ok);
    assign state_d = state_q == IDLE  ? (go ? LOAD : IDLE) :
                     state_q == LOAD  ? (accept && bus.in_last ? DRAIN : LOAD) :
                     state_q == DRAIN ? (wr_en_q ? DRAIN : DONE) : IDLE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_en_q <= wr_en_d;
            err_q   <= err_d;
        end
    end
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = state_q == DONE;
    assign bus.err     = err_q;
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 start  input  1  begin a load session; sampled only in IDLE.
REQ-004 base_addr  input  32  first instruction-memory byte address; latched on accepted start.
REQ-005 in_valid  input  1  instruction descriptor valid.
REQ-006 in_ready  output  1  encoder can accept a descriptor this cycle.
REQ-007 in_op  input  3  0 ADD, 1 SUB, 2 ADDI, 3 LW, 4 SW, 5 BEQ, 6 JAL, 7 JALR.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register indices; ignored where the format has no such field.
REQ-009 in_imm  input  32  signed two's-complement immediate or byte offset.
REQ-010 in_last  input  1  marks the final descriptor of the session.
REQ-011 wr_en  output  1  instruction-memory write request; valid flag of the write port.
REQ-012 wr_addr  output  32  write byte address.
REQ-013 wr_data  output  32  encoded RV32I instruction word.
REQ-014 wr_ready  input  1  memory accepts the write this cycle.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at session end.
REQ-017 err  output  1  sticky: an immediate was out of range this session.

Function
REQ-018 FSM states: IDLE, LOAD, DRAIN, DONE.
REQ-019 IDLE + start=1 -> LOAD; latch base_addr into the address counter; clear err.
REQ-020 start outside IDLE is ignored.
REQ-021 in_ready = (state==LOAD) && (!wr_en || wr_ready); a descriptor is accepted when in_valid && in_ready.
REQ-022 Encoder holds a single-entry output register; an accepted descriptor drives wr_en=1 with its wr_data/wr_addr from the next cycle, 1-cycle latency.
REQ-023 wr_en, wr_addr and wr_data stay stable while wr_en=1 && wr_ready=0.
REQ-024 Write handshake = wr_en && wr_ready; on handshake the address counter increments by 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-025 Handshake and new accept in the same cycle: the register reloads with no bubble, so wr_en remains 1.
REQ-026 Accepted descriptor with in_last=1: LOAD -> DRAIN.
REQ-027 DRAIN with output register empty (wr_en=0) -> DONE; DONE asserts done=1 for one cycle, then -> IDLE.
REQ-028 R-type (ADD/SUB): opcode 0110011, funct3 000, funct7 0000000 for ADD and 0100000 for SUB.
REQ-029 I-type: ADDI opcode 0010011, LW opcode 0000011 funct3 010, JALR opcode 1100111 funct3 000; imm[11:0] in bits 31:20.
REQ-030 S-type SW: opcode 0100011, funct3 010, imm[11:5] in bits 31:25, imm[4:0] in bits 11:7.
REQ-031 B-type BEQ: opcode 1100011, funct3 000, standard split imm[12|10:5|4:1|11].
REQ-032 J-type JAL: opcode 1101111, standard split imm[20|10:1|11|19:12].
REQ-033 Range rules:
  - I/S: -2048..2047.
  - B: -4096..4094, even.
  - J: -1048576..1048574, even.
REQ-034 A violating descriptor is encoded as NOP 0x00000013, sets err=1, and still consumes one address slot.

Reset
REQ-035 On rst=1, asynchronously: state=IDLE; in_ready=0; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0; err=0; any pending write is discarded.
REQ-036 Reset mid-session leaves no residual write after release; the next session requires a new start.

Verification
REQ-037 Basic encode: start, base 0x100, wr_ready=1, then ADDI rd1 rs0 imm5; ADD rd3 rs1 1 rs2 2; SUB (same regs) with in_last -> writes 0x00500093@0x100, 0x002081B3@0x104, 0x402081B3@0x108; then done pulse.
REQ-038 Memory formats: LW rd5 rs1 2 imm8 -> 0x00812283; SW rs2 5 rs1 2 imm12 -> 0x00512623; BEQ rs1 1 rs2 2 imm-4 -> 0xFE208EE3; JAL rd1 imm8 -> 0x008000EF.
REQ-039 Backpressure: wr_ready=0 for 3 cycles with wr_en=1 -> wr_addr/wr_data held, in_ready=0; on release, handshake with no lost or duplicate write.
REQ-040 Range error: ADDI imm 4096, and BEQ imm 3 -> each writes 0x00000013, err=1 sticky until next start, address still advances.
REQ-041 Wrap and start: base 0xFFFFFFFC, two descriptors -> addresses 0xFFFFFFFC then 0x00000000; start asserted while busy has no effect.
REQ-042 Reset mid-session: rst pulse while wr_en=1 and wr_ready=0 -> all outputs zero immediately, state IDLE, no write after release.
